// File: rtl/xor_pulse_drv_pkg.sv
// Shared types and helpers for the XOR pulse-gate stimulus driver.
// Used by xor_pulse_driver, pulse_timer and the bench.
package xor_pulse_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_CLOCK,
    ST_WAIT,
    ST_SAMPLE,
    ST_RESULT
  } drv_state_t;

  localparam int ERR_CNT_W = 16;

  function automatic int bit_period(
    input int s,
    input int h,
    input int o
  );
    return s + h + o + 1;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; done marks the last cycle of a phase.
// Loading N gives N cycles of the phase that follows the load.
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/xor_pulse_driver.sv
// Serialises operand pairs into data/clock pulses for the XOR pulse gate.
// Optional err_cnt output enabled by XOR_PULSE_DRIVER_ERR_CNT_EN.
module xor_pulse_driver
  import xor_pulse_drv_pkg::*;
#(
  parameter int DW            = 8,
  parameter int SETUP_TICKS   = 10,
  parameter int HOLD_TICKS    = 5,
  parameter int OUT_DLY_TICKS = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          a_pulse,
  output logic          b_pulse,
  output logic          clk_pulse,
  input  logic          xor_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_word,
  output logic          res_err
`ifdef XOR_PULSE_DRIVER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int SH   = SETUP_TICKS + HOLD_TICKS;
  localparam int TMAX = (SH > OUT_DLY_TICKS) ? SH : OUT_DLY_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [TW-1:0] SETTLE_LD = TW'(SH - 1);
  localparam logic [TW-1:0] WAIT_LD   = TW'(OUT_DLY_TICKS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DW - 1);

  drv_state_t    state;
  drv_state_t    state_nxt;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          a_bit;
  logic          b_bit;

  assign in_ready  = (state == ST_IDLE);
  assign res_valid = (state == ST_RESULT);

  pulse_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tmr_load  = 1'b0;
    tmr_val   = SETTLE_LD;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_ISSUE;
          idx_nxt   = '0;
        end
      end
      ST_ISSUE: begin
        tmr_load  = 1'b1;
        state_nxt = (SH == 1) ? ST_CLOCK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_done) state_nxt = ST_CLOCK;
      end
      ST_CLOCK: begin
        tmr_load  = 1'b1;
        tmr_val   = WAIT_LD;
        state_nxt = (OUT_DLY_TICKS == 1) ? ST_SAMPLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (tmr_done) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (idx == LAST_IDX) begin
          state_nxt = ST_RESULT;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_RESULT: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pulses are registered off the next state; on accept a_q is not yet loaded.
  assign a_bit = (state == ST_IDLE) ? in_a[0] : a_q[idx_nxt];
  assign b_bit = (state == ST_IDLE) ? in_b[0] : b_q[idx_nxt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_pulse   <= 1'b0;
      b_pulse   <= 1'b0;
      clk_pulse <= 1'b0;
      res_word  <= '0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      a_pulse   <= (state_nxt == ST_ISSUE) & a_bit;
      b_pulse   <= (state_nxt == ST_ISSUE) & b_bit;
      clk_pulse <= (state_nxt == ST_CLOCK);
      if (state == ST_IDLE && in_valid) begin
        a_q      <= in_a;
        b_q      <= in_b;
        res_word <= '0;
        res_err  <= 1'b0;
      end
      if (state == ST_SAMPLE) begin
        res_word[idx] <= xor_out;
        res_err <= res_err | (xor_out ^ a_q[idx] ^ b_q[idx]);
      end
    end
  end

`ifdef XOR_PULSE_DRIVER_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (res_valid && res_ready && res_err && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
